// File: rtl/pe_traffic_node_if.sv
// Network-port bundle for one PE traffic node, named from the node's point of view.
// Handshake: o_data/o_data_val are held stable until a cycle with i_en high; a
// transfer happens on exactly the cycles where o_data_val && i_en.
interface pe_traffic_node_if #(
    parameter int PKT_W = 32
);
    logic [PKT_W-1:0] o_data;
    logic             o_data_val;
    logic             i_en;
    logic [PKT_W-1:0] i_data;
    logic             i_data_val;

    modport master (
        output o_data,
        output o_data_val,
        input  i_en,
        input  i_data,
        input  i_data_val
    );

    modport slave (
        input  o_data,
        input  o_data_val,
        output i_en,
        output i_data,
        output i_data_val
    );
endinterface

// File: rtl/pe_traffic_node.sv
// PE-side traffic endpoint: LFSR-driven packet source with a small queue feeding the
// network injection port, plus a receive sink that tallies count, misdeliveries and latency.
module pe_traffic_node #(
    parameter int NODE_ID    = 0,
    parameter int NODES      = 16,
    parameter int ADDR_W     = 4,
    parameter int TS_W       = 16,
    parameter int SEQ_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PKT_W      = 2*ADDR_W + TS_W + SEQ_W
) (
    input  logic               clk,
    input  logic               reset,
    pe_traffic_node_if.master  net,
    input  logic               i_start,
    input  logic [7:0]         i_rate,
    input  logic [SEQ_W-1:0]   i_max_pkts,
    output logic [SEQ_W-1:0]   o_sent_count,
    output logic [15:0]        o_recv_count,
    output logic [7:0]         o_err_count,
    output logic [31:0]        o_latency_sum,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_dbg_state,
    output logic [SEQ_W-1:0]   o_dbg_gen_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] SELF_ADDR = ADDR_W'(NODE_ID % NODES);

    state_t state_q, state_d;
    logic   start_run;

    logic [TS_W-1:0]  ts_now;
    logic [7:0]       lfsr;
    logic [SEQ_W-1:0] gen_count;
    logic [SEQ_W-1:0] sent_count;

    logic [PKT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_full, fifo_empty;

    logic [PKT_W-1:0] out_data;
    logic             out_val;

    logic             slot_free, gen_fire, fifo_rd, fifo_wr, bypass;
    logic [ADDR_W-1:0] dest_ofs, gen_dest;
    logic [PKT_W-1:0] gen_pkt;

    logic [ADDR_W-1:0] rx_dest;
    logic [TS_W-1:0]   rx_ts, rx_lat;
    logic [15:0]       recv_count;
    logic [7:0]        err_count;
    logic [31:0]       lat_sum;
    logic              rx_unused;

    // ---------------- queue status and datapath control ----------------
    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);

    assign dest_ofs = (lfsr[ADDR_W-1:0] == '0) ? ADDR_W'(1) : lfsr[ADDR_W-1:0];
    assign gen_dest = SELF_ADDR ^ dest_ofs;
    assign gen_pkt  = {gen_dest, SELF_ADDR, ts_now, gen_count};

    // Full is judged before any same-cycle read, so a full queue always refuses the write.
    assign slot_free = !out_val || net.i_en;
    assign gen_fire  = (state_q == RUN) && (lfsr < i_rate) && !fifo_full
                       && (gen_count < i_max_pkts);
    assign fifo_rd   = slot_free && !fifo_empty;
    // An empty queue with a free output slot loads the new packet straight into the
    // output register, giving one cycle from generation to o_data_val.
    assign bypass    = slot_free && fifo_empty && gen_fire;
    assign fifo_wr   = gen_fire && !bypass;

    // ---------------- state machine ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (gen_count == i_max_pkts) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && !out_val) state_d = DONE;
            end
            DONE: begin
                if (i_start) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- timestamp, LFSR and run counters ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_now     <= '0;
            lfsr       <= 8'(NODE_ID + 1);
            gen_count  <= '0;
            sent_count <= '0;
        end else begin
            ts_now <= ts_now + 1'b1;
            if (state_q == RUN)
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (start_run)     gen_count <= '0;
            else if (gen_fire) gen_count <= gen_count + 1'b1;
            if (start_run)                 sent_count <= '0;
            else if (out_val && net.i_en)  sent_count <= sent_count + 1'b1;
        end
    end

    // ---------------- source queue ----------------
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr[PTR_W-1:0]] <= gen_pkt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- injection output register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_val  <= 1'b0;
        end else if (slot_free) begin
            if (fifo_rd) begin
                out_data <= mem[rd_ptr[PTR_W-1:0]];
                out_val  <= 1'b1;
            end else if (bypass) begin
                out_data <= gen_pkt;
                out_val  <= 1'b1;
            end else begin
                out_val  <= 1'b0;
            end
        end
    end

    // ---------------- receive sink ----------------
    assign rx_dest   = net.i_data[PKT_W-1 -: ADDR_W];
    assign rx_ts     = net.i_data[SEQ_W +: TS_W];
    assign rx_lat    = ts_now - rx_ts;
    assign rx_unused = ^{net.i_data[PKT_W-ADDR_W-1 -: ADDR_W], net.i_data[SEQ_W-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recv_count <= '0;
            err_count  <= '0;
            lat_sum    <= '0;
        end else if (net.i_data_val) begin
            recv_count <= recv_count + 1'b1;
            lat_sum    <= lat_sum + 32'(rx_lat);
            if (rx_dest != SELF_ADDR && err_count != 8'hFF)
                err_count <= err_count + 1'b1;
        end
    end

    // ---------------- outputs ----------------
    assign net.o_data      = out_data;
    assign net.o_data_val  = out_val;
    assign o_sent_count    = sent_count;
    assign o_recv_count    = recv_count;
    assign o_err_count     = err_count;
    assign o_latency_sum   = lat_sum;
    assign o_busy          = (state_q == RUN) || (state_q == DRAIN);
    assign o_done          = (state_q == DONE);
    assign o_dbg_state     = state_q;
    assign o_dbg_gen_count = gen_count;

endmodule

// File: tb/tb_pe_traffic_node.sv
// Bench for pe_traffic_node at NODE_ID=5: receive vector table, injection scoreboard
// on sequence numbers, hold-stability monitor, and reset/restart corner sequences.
module tb_pe_traffic_node;

    localparam int NODE_ID = 5;
    localparam int ADDR_W  = 4;
    localparam int TS_W    = 16;
    localparam int SEQ_W   = 8;
    localparam int PKT_W   = 2*ADDR_W + TS_W + SEQ_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             i_start = 1'b0;
    logic [7:0]       i_rate = '0;
    logic [SEQ_W-1:0] i_max_pkts = '0;
    logic [SEQ_W-1:0] o_sent_count;
    logic [15:0]      o_recv_count;
    logic [7:0]       o_err_count;
    logic [31:0]      o_latency_sum;
    logic             o_busy, o_done;
    logic [1:0]       o_dbg_state;
    logic [SEQ_W-1:0] o_dbg_gen_count;

    pe_traffic_node_if #(.PKT_W(PKT_W)) net ();

    pe_traffic_node #(
        .NODE_ID(NODE_ID), .NODES(16), .ADDR_W(ADDR_W), .TS_W(TS_W),
        .SEQ_W(SEQ_W), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .net(net.master),
        .i_start(i_start), .i_rate(i_rate), .i_max_pkts(i_max_pkts),
        .o_sent_count(o_sent_count), .o_recv_count(o_recv_count),
        .o_err_count(o_err_count), .o_latency_sum(o_latency_sum),
        .o_busy(o_busy), .o_done(o_done),
        .o_dbg_state(o_dbg_state), .o_dbg_gen_count(o_dbg_gen_count)
    );

    // Bench's own timestamp: free-running from reset release.
    logic [TS_W-1:0] tb_ts;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 1'b1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [SEQ_W-1:0] exp_q[$];
    logic [SEQ_W-1:0] exp_seq;
    logic [PKT_W-1:0] held_data;
    logic             hold_pending = 1'b0;
    int               val_seen = 0;
    logic [ADDR_W-1:0] m_dest, m_src;
    logic [TS_W-1:0]   m_ts, m_age;
    logic [SEQ_W-1:0]  m_seq;

    always @(negedge clk) begin
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_val", 32'(net.o_data_val), 32'd1);
                check("hold_data", net.o_data, held_data);
            end
            if (net.o_data_val) begin
                val_seen++;
                if (net.i_en) begin
                    {m_dest, m_src, m_ts, m_seq} = net.o_data;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pkt: got seq %0d with empty queue", m_seq);
                    end else begin
                        exp_seq = exp_q.pop_front();
                        check("seq", 32'(m_seq), 32'(exp_seq));
                        check("src", 32'(m_src), 32'(NODE_ID));
                        checks++;
                        if (m_dest == ADDR_W'(NODE_ID)) begin
                            errors++;
                            $display("FAIL dest_not_self: got %0d required not %0d", m_dest, NODE_ID);
                        end
                        m_age = tb_ts - m_ts;
                        checks++;
                        if (m_age > 16'd100) begin
                            errors++;
                            $display("FAIL pkt_age: got %0d required <= 100", m_age);
                        end
                    end
                end
            end
            hold_pending = net.o_data_val && !net.i_en;
            held_data    = net.o_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_start = 1'b0;
        net.i_data_val = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic start_run(input logic [7:0] rate, input logic [SEQ_W-1:0] max_pkts);
        i_rate     = rate;
        i_max_pkts = max_pkts;
        i_start    = 1'b1;
        tick(1);
        i_start    = 1'b0;
    endtask

    task automatic push_seqs(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(SEQ_W'(i));
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!o_done && k < bound) begin
            tick(1);
            k++;
        end
        check("done_reached", 32'(o_done), 32'd1);
    endtask

    task automatic rx_send(input logic [ADDR_W-1:0] dest, input logic [TS_W-1:0] ts);
        net.i_data     = {dest, ADDR_W'(2), ts, SEQ_W'(0)};
        net.i_data_val = 1'b1;
        tick(1);
        net.i_data_val = 1'b0;
    endtask

    typedef struct {
        logic [ADDR_W-1:0] dest;
        logic [TS_W-1:0]   age;
        logic [15:0]       recv;
        logic [7:0]        err;
        logic [31:0]       lat;
    } rx_vec_t;

    rx_vec_t tbl[5];

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        tbl[0] = '{dest: 4'd5,  age: 16'd7,     recv: 16'd1, err: 8'd0, lat: 32'd7};
        tbl[1] = '{dest: 4'd3,  age: 16'd0,     recv: 16'd2, err: 8'd1, lat: 32'd7};
        tbl[2] = '{dest: 4'd5,  age: 16'd100,   recv: 16'd3, err: 8'd1, lat: 32'd107};
        tbl[3] = '{dest: 4'd15, age: 16'd65535, recv: 16'd4, err: 8'd2, lat: 32'd65642};
        tbl[4] = '{dest: 4'd5,  age: 16'd1,     recv: 16'd5, err: 8'd2, lat: 32'd65643};

        net.i_en = 1'b0;
        net.i_data = '0;
        net.i_data_val = 1'b0;

        // Reset then idle
        do_reset();
        tick(50);
        check("idle_val_seen", 32'(val_seen), 32'd0);
        check("idle_data_val", 32'(net.o_data_val), 32'd0);
        check("idle_data", net.o_data, 32'd0);
        check("idle_sent", 32'(o_sent_count), 32'd0);
        check("idle_recv", 32'(o_recv_count), 32'd0);
        check("idle_err", 32'(o_err_count), 32'd0);
        check("idle_lat", o_latency_sum, 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_done", 32'(o_done), 32'd0);

        // Timestamp wrap: DUT ts_now = 2, packet ts = 0xFFFE
        do_reset();
        for (int k = 0; k < 10 && tb_ts != 16'd2; k++) tick(1);
        check("wrap_ts_align", 32'(tb_ts), 32'd2);
        rx_send(4'd5, 16'hFFFE);
        check("wrap_lat", o_latency_sum, 32'd4);
        check("wrap_recv", 32'(o_recv_count), 32'd1);
        check("wrap_err", 32'(o_err_count), 32'd0);

        // Receive vector table, cumulative from reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rx_send(tbl[i].dest, tb_ts - tbl[i].age);
            check($sformatf("rx%0d_recv", i), 32'(o_recv_count), 32'(tbl[i].recv));
            check($sformatf("rx%0d_err", i), 32'(o_err_count), 32'(tbl[i].err));
            check($sformatf("rx%0d_lat", i), o_latency_sum, tbl[i].lat);
        end

        // Error counter saturation with back-to-back misdelivered packets
        net.i_data_val = 1'b1;
        for (int i = 0; i < 260; i++) begin
            net.i_data = {ADDR_W'(0), ADDR_W'(2), tb_ts, SEQ_W'(i)};
            tick(1);
        end
        net.i_data_val = 1'b0;
        tick(1);
        check("sat_err", 32'(o_err_count), 32'd255);
        check("sat_recv", 32'(o_recv_count), 32'd265);
        check("sat_lat", o_latency_sum, 32'd65643);

        // Full rate, no backpressure
        do_reset();
        val_seen = 0;
        net.i_en = 1'b1;
        push_seqs(10);
        start_run(8'd255, 8'd10);
        check("run_busy", 32'(o_busy), 32'd1);
        wait_done(300);
        check("full_q_empty", 32'(exp_q.size()), 32'd0);
        check("full_sent", 32'(o_sent_count), 32'd10);
        check("full_val_seen", 32'(val_seen), 32'd10);
        check("full_busy", 32'(o_busy), 32'd0);

        // Zero-packet run from DONE, then a restart from DONE
        start_run(8'd255, 8'd0);
        wait_done(5);
        check("zero_val_seen", 32'(val_seen), 32'd10);
        check("zero_sent", 32'(o_sent_count), 32'd0);
        push_seqs(3);
        start_run(8'd255, 8'd3);
        wait_done(100);
        check("rerun_q_empty", 32'(exp_q.size()), 32'd0);
        check("rerun_sent", 32'(o_sent_count), 32'd3);

        // Backpressure: 20 stalled cycles, then drain
        do_reset();
        net.i_en = 1'b0;
        push_seqs(8);
        start_run(8'd255, 8'd8);
        tick(20);
        check("stall_val", 32'(net.o_data_val), 32'd1);
        check("stall_sent", 32'(o_sent_count), 32'd0);
        net.i_en = 1'b1;
        wait_done(300);
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);
        check("bp_sent", 32'(o_sent_count), 32'd8);

        // Rate zero: no injection, stays in RUN
        do_reset();
        val_seen = 0;
        start_run(8'd0, 8'd4);
        tick(30);
        check("rate0_val_seen", 32'(val_seen), 32'd0);
        check("rate0_gen", 32'(o_dbg_gen_count), 32'd0);
        check("rate0_state", 32'(o_dbg_state), 32'd1);
        check("rate0_busy", 32'(o_busy), 32'd1);

        // Reset mid-run during a stall, then restart
        do_reset();
        net.i_en = 1'b0;
        push_seqs(8);
        start_run(8'd255, 8'd8);
        tick(10);
        check("pre_rst_val", 32'(net.o_data_val), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_data_val", 32'(net.o_data_val), 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'd0);
        check("rst_sent", 32'(o_sent_count), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(1);
        net.i_en = 1'b1;
        push_seqs(3);
        start_run(8'd255, 8'd3);
        wait_done(100);
        check("restart_q_empty", 32'(exp_q.size()), 32'd0);
        check("restart_sent", 32'(o_sent_count), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
